// File: rtl/lane_judge.sv
// Per-lane note judgement engine: walks the chart ROM, judges tap and hold
// notes against song time, and tracks the combo count.
module lane_judge #(
  parameter int NOTE_COUNT  = 143,
  parameter int PERFECT_WIN = 3,
  parameter int GOOD_WIN    = 6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        run,
  input  logic        frame_tick,
  input  logic [13:0] song_time,
  input  logic        key_pressed,
  input  logic [15:0] key_1,
  input  logic [15:0] key_2,
  output logic [7:0]  addr,
  output logic        judge_valid,
  output logic [1:0]  judge_code,
  output logic        hold_active,
  output logic [9:0]  combo,
  output logic        chart_done
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD,
    DONE
  } state_e;

  localparam logic [1:0] J_PERF = 2'b00;
  localparam logic [1:0] J_GOOD = 2'b01;
  localparam logic [1:0] J_MISS = 2'b10;

  localparam logic signed [14:0] PW = 15'(PERFECT_WIN);
  localparam logic signed [14:0] GW = 15'(GOOD_WIN);
  localparam logic signed [14:0] NP = -PW;
  localparam logic signed [14:0] NG = -GW;
  localparam logic [8:0] NC9 = 9'(NOTE_COUNT);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        key_prev_q;
  logic        jv_q, jv_d;
  logic [1:0]  jc_q, jc_d;
  logic        hold_q, hold_d;
  logic [9:0]  combo_q, combo_d;

  logic signed [14:0] delta;
  logic signed [14:0] mag;
  logic        press, rel;
  logic        in_p, in_g;
  logic        at_end, has_end;
  logic [1:0]  head_t;
  logic        unused_key2;

  assign delta = $signed({1'b0, song_time} - {1'b0, key_1[13:0]});
  assign mag   = delta[14] ? -delta : delta;
  assign in_p  = (mag <= PW);
  assign in_g  = (mag <= GW);
  assign press = key_pressed & ~key_prev_q;
  assign rel   = ~key_pressed & key_prev_q;
  assign head_t = key_1[15:14];
  assign at_end = ({1'b0, addr_q} >= NC9);
  // A hold end past the chart end is not a real partner note.
  assign has_end = (key_2[15:14] == 2'b10) &&
                   (({1'b0, addr_q} + 9'd1) < NC9);
  assign unused_key2 = ^key_2[13:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    jv_d    = 1'b0;
    jc_d    = jc_q;
    combo_d = combo_q;
    if (!run) begin
      state_d = IDLE;
      addr_d  = '0;
      combo_d = '0;
      hold_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ACTIVE;
        ACTIVE: begin
          if (at_end) begin
            state_d = DONE;
          end else if (head_t[1]) begin
            addr_d = addr_q + 8'd1;
          end else if (press && in_g) begin
            jv_d   = 1'b1;
            jc_d   = in_p ? J_PERF : J_GOOD;
            addr_d = addr_q + 8'd1;
            if (head_t == 2'b01 && has_end) begin
              hold_d  = 1'b1;
              state_d = HOLD;
            end
          end else if (frame_tick && delta > GW) begin
            jv_d = 1'b1;
            jc_d = J_MISS;
            if (head_t == 2'b01 && has_end)
              addr_d = addr_q + 8'd2;
            else
              addr_d = addr_q + 8'd1;
          end
        end
        HOLD: begin
          if (frame_tick && key_pressed && !delta[14]) begin
            jv_d = 1'b1;
            jc_d = J_PERF;
          end else if (rel) begin
            jv_d = 1'b1;
            if (delta >= NP)
              jc_d = J_PERF;
            else if (delta >= NG)
              jc_d = J_GOOD;
            else
              jc_d = J_MISS;
          end
          if (jv_d) begin
            addr_d  = addr_q + 8'd1;
            hold_d  = 1'b0;
            state_d = ACTIVE;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    if (jv_d) begin
      if (jc_d == J_MISS)
        combo_d = '0;
      else if (!(&combo_q))
        combo_d = combo_q + 10'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      key_prev_q <= 1'b0;
      jv_q       <= 1'b0;
      jc_q       <= 2'b00;
      hold_q     <= 1'b0;
      combo_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      key_prev_q <= key_pressed;
      jv_q       <= jv_d;
      jc_q       <= jc_d;
      hold_q     <= hold_d;
      combo_q    <= combo_d;
    end
  end

  assign addr        = addr_q;
  assign judge_valid = jv_q;
  assign judge_code  = jc_q;
  assign hold_active = hold_q;
  assign combo       = combo_q;
  assign chart_done  = (state_q == DONE);

endmodule

// File: tb/tb_lane_judge.sv
// Bench for lane_judge: vector table, directed hold/abort/end-of-chart
// sequences, and a randomized song checked against a rule-level model.
module tb_lane_judge;

  localparam int P = 3;
  localparam int G = 6;
  localparam int N = 143;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        frame_tick = 1'b0;
  logic [13:0] song_time = '0;
  logic        key_pressed = 1'b0;

  logic [15:0] rom_a [0:255];
  logic [15:0] rom_b [0:255];

  logic [15:0] k1a, k2a, k1b, k2b;
  logic [7:0]  addr_a, addr_b;
  logic        jv_a, jv_b, hold_a, hold_b, done_a, done_b;
  logic [1:0]  jc_a, jc_b;
  logic [9:0]  combo_a, combo_b;

  assign k1a = rom_a[addr_a];
  assign k2a = rom_a[addr_a + 8'd1];
  assign k1b = rom_b[addr_b];
  assign k2b = rom_b[addr_b + 8'd1];

  lane_judge #(.NOTE_COUNT(N), .PERFECT_WIN(P), .GOOD_WIN(G)) dut (
    .Clk(clk), .Reset_n(rst_n), .run(run), .frame_tick(frame_tick),
    .song_time(song_time), .key_pressed(key_pressed),
    .key_1(k1a), .key_2(k2a), .addr(addr_a), .judge_valid(jv_a),
    .judge_code(jc_a), .hold_active(hold_a), .combo(combo_a),
    .chart_done(done_a)
  );

  lane_judge #(.NOTE_COUNT(2), .PERFECT_WIN(P), .GOOD_WIN(G)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .run(run), .frame_tick(frame_tick),
    .song_time(song_time), .key_pressed(key_pressed),
    .key_1(k1b), .key_2(k2b), .addr(addr_b), .judge_valid(jv_b),
    .judge_code(jc_b), .hold_active(hold_b), .combo(combo_b),
    .chart_done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 0; frame_tick = 0; key_pressed = 0; song_time = '0;
    rst_n = 0;
    #2;
    chk("rst_addr", addr_a, 0);
    chk("rst_jv", jv_a, 0);
    chk("rst_jc", jc_a, 0);
    chk("rst_hold", hold_a, 0);
    chk("rst_combo", combo_a, 0);
    chk("rst_done", done_a, 0);
    rst_n = 1;
    clk1();
  endtask

  task automatic start();
    run = 1;
    clk1();
  endtask

  task automatic hit(input int st, input bit pr, input bit tk);
    song_time = 14'(st);
    key_pressed = pr;
    frame_tick = tk;
    clk1();
    frame_tick = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom_a[i] = '0;
  endtask

  function automatic logic [15:0] note(input int ty, input int t);
    return {2'(ty), 14'(t)};
  endfunction

  typedef struct {
    int ty; int t; int st; bit pr; bit tk; bit ev; int ec; int ea;
  } vec_t;
  vec_t vt [16];

  // Rule-level reference model state.
  int m_mode, m_idx, m_combo, m_jc;
  bit m_hold, m_prev, m_jv;

  task automatic judge(input int c);
    m_jv = 1;
    m_jc = c;
    if (c == 2) m_combo = 0;
    else if (m_combo < 1023) m_combo++;
  endtask

  task automatic model_step();
    bit pr, rl, has_end;
    int ty, d, ad;
    pr = key_pressed && !m_prev;
    rl = !key_pressed && m_prev;
    m_prev = key_pressed;
    m_jv = 0;
    if (!run) begin
      m_mode = 0; m_idx = 0; m_combo = 0; m_hold = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_idx >= N) m_mode = 3;
      else begin
        ty = int'(rom_a[m_idx][15:14]);
        d = int'(song_time) - int'(rom_a[m_idx][13:0]);
        ad = d < 0 ? -d : d;
        has_end = (rom_a[m_idx+1][15:14] == 2'b10) && (m_idx + 1 < N);
        if (ty >= 2) m_idx++;
        else if (pr && ad <= G) begin
          judge(ad <= P ? 0 : 1);
          m_idx++;
          if (ty == 1 && has_end) begin m_hold = 1; m_mode = 2; end
        end else if (frame_tick && d > G) begin
          judge(2);
          m_idx += (ty == 1 && has_end) ? 2 : 1;
        end
      end
    end else if (m_mode == 2) begin
      d = int'(song_time) - int'(rom_a[m_idx][13:0]);
      if (frame_tick && key_pressed && d >= 0) judge(0);
      else if (rl) judge(d >= -P ? 0 : (d >= -G ? 1 : 2));
      if (m_jv) begin m_idx++; m_hold = 0; m_mode = 1; end
    end
  endtask

  initial begin
    int t, ev, e;
    int cyc, done_cnt;
    for (int i = 0; i < 256; i++) rom_b[i] = '0;
    rom_b[0] = note(0, 100);
    rom_b[1] = note(0, 120);
    clear_rom();
    #1;

    vt[0]  = '{0, 100, 102, 1, 0, 1, 0, 1};
    vt[1]  = '{0, 100,  95, 1, 0, 1, 1, 1};
    vt[2]  = '{0, 100,  90, 1, 0, 0, 0, 0};
    vt[3]  = '{0, 100, 103, 1, 0, 1, 0, 1};
    vt[4]  = '{0, 100, 104, 1, 0, 1, 1, 1};
    vt[5]  = '{0, 100, 106, 1, 0, 1, 1, 1};
    vt[6]  = '{0, 100, 107, 1, 0, 0, 0, 0};
    vt[7]  = '{0, 100,  97, 1, 0, 1, 0, 1};
    vt[8]  = '{0, 100,  94, 1, 0, 1, 1, 1};
    vt[9]  = '{0, 100,  93, 1, 0, 0, 0, 0};
    vt[10] = '{0, 100, 107, 0, 1, 1, 2, 1};
    vt[11] = '{0, 100, 106, 0, 1, 0, 0, 0};
    vt[12] = '{0, 100, 110, 1, 1, 1, 2, 1};
    vt[13] = '{0, 100, 104, 1, 1, 1, 1, 1};
    vt[14] = '{3, 100,   0, 0, 0, 0, 0, 1};
    vt[15] = '{2, 100,   0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 16; i++) begin
      do_reset();
      rom_a[0] = note(vt[i].ty, vt[i].t);
      rom_a[1] = note(0, 500);
      start();
      hit(vt[i].st, vt[i].pr, vt[i].tk);
      chk($sformatf("vec%0d_jv", i), jv_a, vt[i].ev);
      if (vt[i].ev) chk($sformatf("vec%0d_jc", i), jc_a, vt[i].ec);
      chk($sformatf("vec%0d_addr", i), addr_a, vt[i].ea);
      chk($sformatf("vec%0d_combo", i), combo_a,
          (vt[i].ev && vt[i].ec < 2) ? 1 : 0);
      clk1();
      chk($sformatf("vec%0d_jv_pulse", i), jv_a, 0);
    end

    // Five hits build combo, then a Miss clears it.
    do_reset();
    for (int i = 0; i < 5; i++) rom_a[i] = note(0, 100 + 20 * i);
    rom_a[5] = note(0, 200);
    start();
    for (int i = 0; i < 5; i++) begin
      hit(100 + 20 * i, 1, 0);
      chk("combo_build", combo_a, i + 1);
      hit(101 + 20 * i, 0, 0);
    end
    hit(207, 0, 1);
    chk("combo_miss_jv", jv_a, 1);
    chk("combo_miss_jc", jc_a, 2);
    chk("combo_miss_addr", addr_a, 6);
    chk("combo_miss_val", combo_a, 0);
    clk1();
    chk("jc_held", jc_a, 2);

    // Hold held to the end.
    do_reset();
    rom_a[0] = note(1, 200);
    rom_a[1] = note(2, 220);
    rom_a[2] = note(0, 400);
    start();
    hit(201, 1, 0);
    chk("hold_start_jv", jv_a, 1);
    chk("hold_start_jc", jc_a, 0);
    chk("hold_start_active", hold_a, 1);
    chk("hold_start_addr", addr_a, 1);
    hit(210, 1, 1);
    chk("hold_mid_jv", jv_a, 0);
    chk("hold_mid_active", hold_a, 1);
    hit(220, 1, 1);
    chk("hold_end_jv", jv_a, 1);
    chk("hold_end_jc", jc_a, 0);
    chk("hold_end_active", hold_a, 0);
    chk("hold_end_addr", addr_a, 2);
    chk("hold_end_combo", combo_a, 2);

    // Early release -> Miss.
    do_reset();
    start();
    hit(201, 1, 0);
    hit(210, 0, 0);
    chk("hold_rel_jv", jv_a, 1);
    chk("hold_rel_jc", jc_a, 2);
    chk("hold_rel_addr", addr_a, 2);
    chk("hold_rel_combo", combo_a, 0);

    // Release inside the Good window.
    do_reset();
    start();
    hit(201, 1, 0);
    hit(215, 0, 0);
    chk("hold_good_jc", jc_a, 1);
    chk("hold_good_combo", combo_a, 2);

    // Missed hold start: one Miss, skip both entries.
    do_reset();
    start();
    hit(207, 0, 1);
    chk("hmiss_jv", jv_a, 1);
    chk("hmiss_jc", jc_a, 2);
    chk("hmiss_addr", addr_a, 2);
    chk("hmiss_hold", hold_a, 0);
    hit(208, 0, 1);
    chk("hmiss_once", jv_a, 0);
    chk("hmiss_addr2", addr_a, 2);

    // run drop while holding.
    do_reset();
    start();
    hit(201, 1, 0);
    run = 0;
    clk1();
    chk("abort_addr", addr_a, 0);
    chk("abort_hold", hold_a, 0);
    chk("abort_jv", jv_a, 0);
    chk("abort_combo", combo_a, 0);

    // Asynchronous reset while holding.
    do_reset();
    start();
    hit(201, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk("areset_hold", hold_a, 0);
    chk("areset_addr", addr_a, 0);
    chk("areset_jv", jv_a, 0);
    chk("areset_combo", combo_a, 0);
    rst_n = 1;

    // Two-note chart runs out.
    do_reset();
    start();
    hit(100, 1, 0);
    hit(101, 0, 0);
    hit(120, 1, 0);
    chk("end_addr", addr_b, 2);
    chk("end_done_early", done_b, 0);
    clk1();
    chk("end_done", done_b, 1);
    for (int i = 0; i < 3; i++) clk1();
    chk("end_done_stays", done_b, 1);
    chk("end_addr_cap", addr_b, 2);
    run = 0;
    clk1();
    chk("end_done_clear", done_b, 0);
    chk("end_addr_clear", addr_b, 0);

    // Randomized song against the model.
    do_reset();
    clear_rom();
    begin
      int i;
      i = 0; t = 20;
      while (i < N) begin
        e = int'($urandom_range(0, 9));
        if (e < 6) begin
          rom_a[i] = note(0, t); i++;
        end else if (e < 8 && i + 1 < N) begin
          ev = t + int'($urandom_range(10, 40));
          rom_a[i] = note(1, t);
          rom_a[i+1] = note(2, ev);
          i += 2; t = ev;
        end else begin
          rom_a[i] = note(e == 8 ? 3 : 2, t); i++;
        end
        t += int'($urandom_range(6, 20));
      end
    end
    m_mode = 0; m_idx = 0; m_combo = 0; m_hold = 0; m_prev = 0;
    m_jv = 0; m_jc = 0;
    run = 1;
    cyc = 0; done_cnt = 0;
    while (cyc < 40000 && done_cnt < 5) begin
      cyc++;
      if (cyc == 1500) run = 0;
      if (cyc == 1504) begin run = 1; song_time = '0; end
      frame_tick = ($urandom_range(0, 3) == 0);
      if (frame_tick && song_time != 14'h3fff) song_time = song_time + 14'd1;
      if ($urandom_range(0, 4) == 0) key_pressed = ~key_pressed;
      model_step();
      clk1();
      chk("r_addr", addr_a, m_idx);
      chk("r_jv", jv_a, m_jv);
      if (m_jv) chk("r_jc", jc_a, m_jc);
      chk("r_combo", combo_a, m_combo);
      chk("r_hold", hold_a, m_hold);
      chk("r_done", done_a, m_mode == 3);
      if (m_mode == 3) done_cnt++;
    end
    chk("r_reached_done", done_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
